// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART frame scheduler.
// Build option DBG_UART_CKSUM_EN adds a trailing XOR checksum byte to every frame.
package dbg_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_B3,
    ST_B2,
    ST_B1,
`ifdef DBG_UART_CKSUM_EN
    ST_B0,
    ST_CKS
`else
    ST_B0
`endif
  } state_t;

  localparam logic [5:0] HDR_MAGIC_DEF = 6'b101000;

`ifdef DBG_UART_CKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  function automatic logic [7:0] hdr_byte(input logic [5:0] magic, input logic [1:0] id);
    return {magic, id};
  endfunction

endpackage

// File: rtl/dbg_uart_rr_arbiter.sv
// Round-robin arbiter: picks the first request after the last winner, wrapping.
// Returns the grant as one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [IW-1:0] ptr;

  // Search starts one past the pointer so the last winner is checked last.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
    end else if (upd && gnt_any) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/dbg_uart_sched.sv
// Shares one UART byte transmitter among NREQ debug-word sources; each grant becomes a tagged frame.
// Build option DBG_UART_CKSUM_EN appends an XOR checksum byte (6-byte frames instead of 5).
//
// state | meaning
// IDLE  | no frame; arbitrate among requests
// HDR   | sending {HDR_MAGIC, id}
// B3-B0 | sending latched word, MSB first
// CKS   | sending XOR of all previous frame bytes (checksum build only)
module dbg_uart_sched
  import dbg_uart_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter logic [5:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic               CLK100MHZ,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            grant;
  logic [31:0]     sel_word;
  logic [31:0]     word;
  logic [1:0]      id;
  logic [7:0]      hdr;

  assign grant = (state == ST_IDLE) && gnt_any;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk     (CLK100MHZ),
    .rst_n   (rst_n),
    .req     (req),
    .upd     (grant),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) sel_word = req_data[32*i +: 32];
    end
  end

  // The word is captured at grant so later req_data changes cannot corrupt the frame.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      word  <= '0;
      id    <= '0;
      ack   <= '0;
    end else begin
      state <= state_n;
      ack   <= grant ? gnt_oh : '0;
      if (grant) begin
        word <= sel_word;
        id   <= 2'(gnt_idx);
      end
    end
  end

  assign hdr = hdr_byte(HDR_MAGIC, id);

`ifdef DBG_UART_CKSUM_EN
  logic [7:0] cks;
  assign cks = hdr ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
`endif

  always_comb begin
    state_n = state;
    tx_data = 8'h00;
    case (state)
      ST_IDLE: if (gnt_any) state_n = ST_HDR;
      ST_HDR: begin
        tx_data = hdr;
        if (tx_ready) state_n = ST_B3;
      end
      ST_B3: begin
        tx_data = word[31:24];
        if (tx_ready) state_n = ST_B2;
      end
      ST_B2: begin
        tx_data = word[23:16];
        if (tx_ready) state_n = ST_B1;
      end
      ST_B1: begin
        tx_data = word[15:8];
        if (tx_ready) state_n = ST_B0;
      end
      ST_B0: begin
        tx_data = word[7:0];
`ifdef DBG_UART_CKSUM_EN
        if (tx_ready) state_n = ST_CKS;
      end
      ST_CKS: begin
        tx_data = cks;
        if (tx_ready) state_n = ST_IDLE;
`else
        if (tx_ready) state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign tx_valid = busy;

endmodule

// File: tb/tb_dbg_uart_sched.sv
// Scoreboard bench for dbg_uart_sched: expected frame bytes are queued at stimulus time
// and popped as the transmitter accepts bytes.
module tb_dbg_uart_sched;
  import dbg_uart_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  dbg_uart_sched #(.NREQ(4)) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of one frame: header, word MSB first, optional XOR checksum.
  task automatic push_frame(input logic [1:0] id, input logic [31:0] w);
    logic [7:0] h;
    h = {6'b101000, id};
    exp_q.push_back(h);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`ifdef DBG_UART_CKSUM_EN
    exp_q.push_back(h ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
  endtask

  always @(negedge clk) begin
    if (hold_pend && tx_valid) chk("hold_data", {24'h0, tx_data}, {24'h0, hold_byte});
    hold_pend = tx_valid && !tx_ready;
    hold_byte = tx_data;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else chk("byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_ack(input string tag, input logic [3:0] exp_ack);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'h0 && n < 60);
    if (ack == 4'h0) chk({tag, "_timeout"}, 32'h0, 32'h1);
    else chk(tag, {28'h0, ack}, {28'h0, exp_ack});
  endtask

  task automatic drain(input string tag, input bit bp);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      if (bp) tx_ready = (n % 4 == 0) || (n % 4 == 3);
      n++;
    end
    tx_ready = 1'b1;
    if (n >= 200) chk({tag, "_drain_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int n;
    logic [31:0] dw [4];
    for (int i = 0; i < 4; i++) dw[i] = 32'h10203040 + i * 32'h01010101;

    // Reset with every source requesting.
    rst_n    = 1'b0;
    req      = 4'b1111;
    req_data = {dw[3], dw[2], dw[1], dw[0]};
    tx_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", {28'h0, ack}, 32'h0);
      chk("rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_data", {24'h0, tx_data}, 32'h0);
    end
    push_frame(2'd0, dw[0]);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ack("first_grant", 4'b0001);
    req = 4'b0000;
    drain("first", 1'b0);

    // Single frame, ready tied high.
    req_data[95:64] = 32'hDEADBEEF;
    push_frame(2'd2, 32'hDEADBEEF);
    @(posedge clk); #1;
    req[2] = 1'b1;
    wait_ack("single_ack", 4'b0100);
    req[2] = 1'b0;
    req_data[95:64] = 32'h0;
    @(negedge clk);
    chk("ack_pulse", {28'h0, ack}, 32'h0);
    n = 1;
    while (tx_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("frame_len", n, FRAME_LEN);
    chk("busy_after", {31'h0, busy}, 32'h0);
    drain("single", 1'b0);

    // Same frame with backpressure from the first byte.
    req_data[95:64] = 32'hDEADBEEF;
    push_frame(2'd2, 32'hDEADBEEF);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    req[2]   = 1'b1;
    wait_ack("bp_ack", 4'b0100);
    req[2] = 1'b0;
    drain("bp", 1'b1);

    // Reset after B3 transfers.
    req_data[127:96] = 32'hCAFEF00D;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hCA);
    @(posedge clk); #1;
    req[3] = 1'b1;
    wait_ack("mid_ack", 4'b1000);
    req[3] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (exp_q.size() != 0 && n < 50);
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst_n            = 1'b1;
    tx_ready         = 1'b1;
    req_data[63:32]  = 32'h0BADF00D;
    push_frame(2'd1, 32'h0BADF00D);
    req[1] = 1'b1;
    wait_ack("fresh_ack", 4'b0010);
    req[1] = 1'b0;
    drain("fresh", 1'b0);

    // Round-robin from a clean pointer with all sources held.
    @(posedge clk); #1;
    rst_n    = 1'b0;
    req_data = {dw[3], dw[2], dw[1], dw[0]};
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) push_frame(2'(k % 4), dw[k % 4]);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) wait_ack("rr_ack", 4'b0001 << (k % 4));
    req = 4'b0000;
    drain("rr", 1'b0);

    // Source 0 with the checksum reference word.
    req_data[31:0] = 32'h12345678;
    push_frame(2'd0, 32'h12345678);
    @(posedge clk); #1;
    req[0] = 1'b1;
    wait_ack("cks_ack", 4'b0001);
    req[0] = 1'b0;
    drain("cks", 1'b0);

    chk("leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
